// File: rtl/charge_controller_if.sv
// Bus interface for charge_controller: charger/request inputs and level/status outputs.
interface charge_controller_if #(
    parameter int unsigned N = 9
);
    logic         plug;
    logic         start;
    logic [N-1:0] level_in;
    logic [N-1:0] max_level;
    logic [N-1:0] level;
    logic         charging;
    logic         full;
    logic         done;
    logic         aborted;
    logic         warn;

    // Stimulus side: drives charger state and capture values, observes status
    modport master (
        output plug,
        output start,
        output level_in,
        output max_level,
        input  level,
        input  charging,
        input  full,
        input  done,
        input  aborted,
        input  warn
    );

    // Controller side
    modport slave (
        input  plug,
        input  start,
        input  level_in,
        input  max_level,
        output level,
        output charging,
        output full,
        output done,
        output aborted,
        output warn
    );
endinterface

// File: rtl/charge_controller.sv
// Lightsaber power cell recharge controller: counts the remaining battery
// time back up to the programmed maximum while the charger is connected.
// Optional build macro CHG_FAST_EN: double step size while below half of max.
module charge_controller #(
    parameter int unsigned N          = 9,
    parameter int unsigned DIV        = 4,
    parameter int unsigned STEP       = 1,
    parameter int unsigned WARN_LEVEL = 45
) (
    input  logic                clk,
    input  logic                rst,
    charge_controller_if.slave  bus
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [N:0]    STEP_1X    = (N+1)'(STEP);
`ifdef CHG_FAST_EN
    localparam logic [N:0]    STEP_2X    = (N+1)'(2 * STEP);
`endif
    localparam logic [N-1:0]  WARN_TH    = N'(WARN_LEVEL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHARGE = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [N-1:0]  level_q,   level_d;
    logic [N-1:0]  max_q,     max_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          done_q,    done_d;
    logic          aborted_q, aborted_d;

    logic [N-1:0]  cap_level;
    logic [N:0]    inc;
    logic [N:0]    sum;
    logic [N-1:0]  sat_level;

    // Starting level is the captured level clamped to the target
    assign cap_level = (bus.level_in < bus.max_level) ? bus.level_in : bus.max_level;

`ifdef CHG_FAST_EN
    // Fast charge below half of target, normal step above
    assign inc = (level_q < (max_q >> 1)) ? STEP_2X : STEP_1X;
`else
    assign inc = STEP_1X;
`endif

    // One bit of headroom so the step can never wrap before saturation
    assign sum       = {1'b0, level_q} + inc;
    assign sat_level = (sum >= {1'b0, max_q}) ? max_q : sum[N-1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            level_q   <= '0;
            max_q     <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            max_q     <= max_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state, datapath update and pulse generation
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        max_d     = max_q;
        presc_d   = '0;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.plug) begin
                    level_d = cap_level;
                    max_d   = bus.max_level;
                    if (cap_level == bus.max_level) begin
                        state_d = S_FULL;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CHARGE;
                    end
                end
            end

            S_CHARGE: begin
                if (!bus.plug) begin
                    // Unplug wins over a coincident step; level is frozen
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (presc_q == PRESC_LAST) begin
                    level_d = sat_level;
                    if (sat_level == max_q) begin
                        state_d = S_FULL;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_FULL: begin
                if (!bus.plug) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decode straight from registered state/level
    assign bus.level    = level_q;
    assign bus.charging = (state_q == S_CHARGE);
    assign bus.full     = (state_q == S_FULL);
    assign bus.done     = done_q;
    assign bus.aborted  = aborted_q;
    assign bus.warn     = (level_q < WARN_TH);

endmodule

// File: doc/charge_controller.md
Name: charge_controller

Overview:
- Recharge side of the lightsaber power cell: the opposite direction to the discharge saturation counter.
- Takes the remaining battery time (seconds) from the discharge path and counts it back up to the programmed maximum while the charger is connected.
- Flags completion and drives status/warning outputs for the error-state display.

Parameters:
- N, 9, width of level/max buses (seconds).
- DIV, 4, clock cycles per charge step (prescaler period, must be >= 1).
- STEP, 1, seconds added per charge step.
- WARN_LEVEL, 45, level below which warn is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- plug  input  1  charger connected.
- start  input  1  request to begin charging; sampled each cycle in IDLE.
- level_in  input  N  remaining battery time captured on start.
- max_level  input  N  full-charge target captured on start.
- level  output  N  current charge level (registered).
- charging  output  1  high while in CHARGE.
- full  output  1  high while in FULL.
- done  output  1  one-cycle pulse on CHARGE->FULL.
- aborted  output  1  one-cycle pulse when plug drops during CHARGE.
- warn  output  1  level < WARN_LEVEL (combinational from level register).

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, level=0, max_r=0, prescaler=0, done=0, aborted=0. Hence charging=0, full=0, warn=1. Reset mid-charge discards progress.
- States: IDLE, CHARGE, FULL. Encoding is free; charging and full decode directly from state.
- IDLE:
  - start=1 and plug=1 at an edge: level <= min(level_in, max_level) and max_r <= max_level.
  - Next state is FULL if min(level_in, max_level) == max_level, otherwise CHARGE with prescaler=0.
  - Entering FULL directly from IDLE also pulses done.
  - start with plug=0 is ignored; level is held.
- CHARGE:
  - Prescaler counts 0..DIV-1 and wraps.
  - At the edge where prescaler==DIV-1: level <= level+STEP, saturated at max_r. The addition uses N+1 bits, so there is no wrap-around.
  - The first increment is visible DIV cycles after CHARGE is entered.
  - When the updated level equals max_r: next state FULL, done=1 for exactly that cycle.
- plug=0 in CHARGE: next state IDLE, level held, aborted=1 for one cycle. Abort takes priority over a same-cycle increment, so level is not updated on that edge.
- start in CHARGE or FULL is ignored. level_in and max_level changes after capture are ignored.
- FULL: level==max_r, held. plug=0 gives next state IDLE with level retained; done and aborted stay 0.
- max_level=0 on start: goes straight to FULL with level=0.
- done and aborted are never high in the same cycle.

Optional Feature:
- Macro: CHG_FAST_EN.
- Defined: while level < max_r/2 (integer shift right by 1), each step adds 2*STEP, still saturating at max_r; above half, STEP as normal.
- Undefined: every step adds STEP. Ports and states are identical in both builds.

Test Plan:
- Reset: drive rst=0 mid-CHARGE with level=100 -> same cycle level=0, charging=0, warn=1. Release and no start -> remains IDLE.
- Normal charge: DIV=4, STEP=1, plug=1, start pulse with level_in=45, max_level=180 -> charging=1 next cycle. level=46 four cycles later. level=180 after 540 CHARGE cycles with done pulsed once, then full=1. warn falls when level reaches 45.
- Saturation/clamp:
  - STEP=7, level_in=175, max_level=180 -> 182 = 175+7 saturates to level=180 and done.
  - Separately, level_in=200, max_level=180 -> level=180, immediate FULL, done pulse.
- Abort: unplug at level=60 in CHARGE on the edge where prescaler==DIV-1 -> level stays 60, aborted one cycle, IDLE. A replug plus start with level_in=60 resumes.
- Ignored inputs: start with plug=0 -> stays IDLE. Start during CHARGE/FULL and a level_in change mid-charge -> no effect on level or state.
- CHG_FAST_EN: DIV=1, STEP=1, level_in=0, max_level=10 -> levels 2,4,6,7,8,9,10, done after 7 cycles. Without the macro: 10 cycles.
